yamin_dcu_ram_arb: RTL

//  Parametrised arbiter for DCU tag/data RAM port; replaces fixed per-client has_priority/ack logic.
//  NUM_REQ clients (LSU, STB, BIU alloc, BIU ev, PF lookup, maint) request in M0; one-hot grant in M0; registered ack in M1.

---
 rtl/yamin_dcu_pkg.sv | 20 ++
 rtl/yamin_dcu_arb_age.sv | 51 +++++
 rtl/yamin_dcu_ram_arb.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/yamin_dcu_pkg.sv
// Shared definitions for the DCU tag/data RAM port arbiter: client indices
// and the arbitration FSM state type.
package yamin_dcu_pkg;

   // Requester slots, index 0 has the highest fixed priority
   localparam int ARB_LSU         = 0;
   localparam int ARB_STB         = 1;
   localparam int ARB_BIU_ALLOC   = 2;
   localparam int ARB_BIU_EV      = 3;
   localparam int ARB_PF          = 4;
   localparam int ARB_MAINT       = 5;
   localparam int ARB_NUM_CLIENTS = 6;

   typedef enum logic [1:0] {
      ARB     = 2'd0,
      LOCK    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/yamin_dcu_arb_age.sv
// Per-requester starvation age counter. Counts cycles a request waits without
// a grant, saturates at STARVE_LIMIT and flags the requester as starved there.
module yamin_dcu_arb_age #(
   parameter int AGE_W        = 4,
   parameter int STARVE_LIMIT = 12
)(
   input  logic clk,
   input  logic csysreset_n,
   input  logic i_req,
   input  logic i_grant,
   input  logic i_hold,
   output logic o_starved,
   output logic o_reach
);

   localparam logic [AGE_W-1:0] LIMIT      = AGE_W'(STARVE_LIMIT);
   localparam logic [AGE_W-1:0] LIMIT_LESS = AGE_W'(STARVE_LIMIT - 1);

   logic [AGE_W-1:0] r_age;
   logic [AGE_W-1:0] w_age_next;
   logic             w_wait;

   // A request is waiting when it is present, not granted and the RAM is live
   assign w_wait = i_req & ~i_grant & ~i_hold;

   // Next age: frozen under hold, cleared on grant or dropped request
   always_comb begin
      w_age_next = r_age;
      if (!i_hold) begin
         if (!i_req || i_grant) begin
            w_age_next = '0;
         end else if (r_age != LIMIT) begin
            w_age_next = r_age + AGE_W'(1);
         end
      end
   end

   // Age register
   always_ff @(posedge clk or negedge csysreset_n) begin
      if (!csysreset_n) begin
         r_age <= '0;
      end else begin
         r_age <= w_age_next;
      end
   end

   assign o_starved = (r_age == LIMIT);
   // Asserted in the cycle whose update takes the age up to the limit
   assign o_reach   = w_wait && (r_age == LIMIT_LESS);

endmodule

// File: rtl/yamin_dcu_ram_arb.sv
// DCU tag/data RAM port arbiter. Grants one client per M0 cycle using fixed
// priority with starvation override, supports multi-beat locked bursts with
// a beat limit, and acknowledges the granted client one cycle later (M1).
module yamin_dcu_ram_arb
   import yamin_dcu_pkg::*;
#(
   parameter int NUM_REQ      = ARB_NUM_CLIENTS,
   parameter int AGE_W        = 4,
   parameter int STARVE_LIMIT = 12,
   parameter int LOCK_MAX     = 8
)(
   input  logic                       clk,
   input  logic                       csysreset_n,
   input  logic [NUM_REQ-1:0]         req_m0_i,
   input  logic [NUM_REQ-1:0]         lock_m0_i,
   input  logic                       hold_i,
   output logic [NUM_REQ-1:0]         has_priority_m0_o,
   output logic [NUM_REQ-1:0]         ack_m1_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_m1_o,
   output logic                       starve_o,
   output logic                       lock_timeout_o
);

   localparam int                IDX_W     = $clog2(NUM_REQ);
   localparam int                BEAT_W    = $clog2(LOCK_MAX + 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LOCK_MAX - 1);

   arb_state_t         r_state;
   arb_state_t         w_state_next;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   w_owner_next;
   logic [BEAT_W-1:0]  r_beat;
   logic [BEAT_W-1:0]  w_beat_next;
   logic [NUM_REQ-1:0] r_ack;
   logic [IDX_W-1:0]   r_grant_idx;

   logic               w_run;
   logic [NUM_REQ-1:0] w_starved;
   logic [NUM_REQ-1:0] w_reach;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic [NUM_REQ-1:0] w_req_masked;
   logic [NUM_REQ-1:0] w_starved_req;
   logic [NUM_REQ-1:0] w_cand;
   logic [NUM_REQ-1:0] w_arb_oh;
   logic [IDX_W-1:0]   w_arb_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_timeout;

   // Index of the lowest set bit, 0 for an empty vector
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // Outputs stay quiet while in reset as well as during hold
   assign w_run = csysreset_n & ~hold_i;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
         yamin_dcu_arb_age #(
            .AGE_W        (AGE_W),
            .STARVE_LIMIT (STARVE_LIMIT)
         ) u_age (
            .clk         (clk),
            .csysreset_n (csysreset_n),
            .i_req       (req_m0_i[gi]),
            .i_grant     (w_grant[gi]),
            .i_hold      (~w_run),
            .o_starved   (w_starved[gi]),
            .o_reach     (w_reach[gi])
         );
      end
   endgenerate

   // Arbitration candidates: owner masked out for one cycle after a forced
   // release; starved requesters take precedence over fixed priority
   always_comb begin
      w_owner_oh    = NUM_REQ'(1) << r_owner;
      w_req_masked  = (r_state == RELEASE) ? (req_m0_i & ~w_owner_oh) : req_m0_i;
      w_starved_req = w_starved & w_req_masked;
      w_cand        = (|w_starved_req) ? w_starved_req : w_req_masked;
      w_arb_oh      = w_cand & (~w_cand + NUM_REQ'(1));
      w_arb_idx     = lowest_idx(w_cand);
   end

   // Next-state, grant and lock beat accounting
   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_beat_next  = r_beat;
      w_grant      = '0;
      w_grant_idx  = '0;
      w_timeout    = 1'b0;
      if (w_run) begin
         case (r_state)
            LOCK: begin
               if (req_m0_i[r_owner]) begin
                  w_grant     = w_owner_oh;
                  w_grant_idx = r_owner;
                  if (lock_m0_i[r_owner]) begin
                     if (r_beat == BEAT_LAST) begin
                        w_state_next = RELEASE;
                        w_beat_next  = '0;
                        w_timeout    = 1'b1;
                     end else begin
                        w_beat_next = r_beat + BEAT_W'(1);
                     end
                  end else begin
                     w_state_next = ARB;
                     w_beat_next  = '0;
                  end
               end else begin
                  // Owner went away: no grant this cycle, arbitrate next cycle
                  w_state_next = ARB;
                  w_beat_next  = '0;
               end
            end
            default: begin
               w_grant      = w_arb_oh;
               w_grant_idx  = w_arb_idx;
               w_state_next = ARB;
               if ((|w_arb_oh) && lock_m0_i[w_arb_idx]) begin
                  w_state_next = LOCK;
                  w_owner_next = w_arb_idx;
                  w_beat_next  = BEAT_W'(1);
               end
            end
         endcase
      end
   end

   // FSM state, lock owner and beat counter
   always_ff @(posedge clk or negedge csysreset_n) begin
      if (!csysreset_n) begin
         r_state <= ARB;
         r_owner <= '0;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
         r_beat  <= w_beat_next;
      end
   end

   // M1 acknowledge and index of the acknowledged client
   always_ff @(posedge clk or negedge csysreset_n) begin
      if (!csysreset_n) begin
         r_ack       <= '0;
         r_grant_idx <= '0;
      end else begin
         r_ack       <= w_grant & req_m0_i;
         r_grant_idx <= w_grant_idx;
      end
   end

   assign has_priority_m0_o = w_grant;
   assign ack_m1_o          = r_ack;
   assign grant_idx_m1_o    = r_grant_idx;
   assign starve_o          = |w_reach;
   assign lock_timeout_o    = w_timeout;

endmodule
